// File: rtl/reg_writeback_buffer.sv
// rtl/reg_writeback_buffer.sv - register-file writeback arbiter with a 4-entry queue for long-latency results
// Optional macro WB_BYPASS_EN lets a B request skip an empty queue and issue with 1-cycle latency.
module reg_writeback_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic [4:0]  q_reg1,
  input  logic [4:0]  q_reg2,
  output logic        q_busy1,
  output logic        q_busy2,
  output logic        regWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic [2:0]  count
);

  logic [3:0]  ent_v;
  logic [4:0]  ent_reg  [4];
  logic [31:0] ent_data [4];
  logic [1:0]  wptr;
  logic [1:0]  rptr;

  logic a_issue;
  logic pop;
  logic push;
  logic bypass;

  assign b_ready = (count != 3'd4);
  assign a_issue = a_valid && (a_reg != 5'd0);
  assign pop     = !a_issue && (count != 3'd0);

`ifdef WB_BYPASS_EN
  assign bypass = !a_issue && (count == 3'd0) && b_valid && (b_reg != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Zero-register B requests are acknowledged but never stored.
  assign push = b_valid && b_ready && (b_reg != 5'd0) && !bypass;

  function automatic logic reg_busy(input logic [4:0] q);
    logic hit;
    hit = regWrite && (WriteRegister == q);
    for (int i = 0; i < 4; i++) begin
      if (ent_v[i] && (ent_reg[i] == q)) hit = 1'b1;
    end
    return (q != 5'd0) && hit;
  endfunction

  assign q_busy1 = reg_busy(q_reg1);
  assign q_busy2 = reg_busy(q_reg2);

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
      wptr          <= 2'd0;
      rptr          <= 2'd0;
      count         <= 3'd0;
      ent_v         <= 4'd0;
    end else begin
      if (a_issue) begin
        regWrite      <= 1'b1;
        WriteRegister <= a_reg;
        WriteData     <= a_data;
      end else if (pop && ent_v[rptr]) begin
        regWrite      <= 1'b1;
        WriteRegister <= ent_reg[rptr];
        WriteData     <= ent_data[rptr];
      end else if (bypass) begin
        regWrite      <= 1'b1;
        WriteRegister <= b_reg;
        WriteData     <= b_data;
      end else begin
        regWrite      <= 1'b0;
      end

      // A newer A write kills queued writes to the same register so they cannot land later.
      for (int i = 0; i < 4; i++) begin
        if (a_issue && (ent_reg[i] == a_reg)) ent_v[i] <= 1'b0;
      end

      if (pop) begin
        ent_v[rptr] <= 1'b0;
        rptr        <= rptr + 2'd1;
      end

      if (push) begin
        ent_v[wptr]    <= 1'b1;
        ent_reg[wptr]  <= b_reg;
        ent_data[wptr] <= b_data;
        wptr           <= wptr + 2'd1;
      end

      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// tb/tb_reg_writeback_buffer.sv - directed vector bench for reg_writeback_buffer
module tb_reg_writeback_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic [4:0]  q_reg1;
  logic [4:0]  q_reg2;
  logic        q_busy1;
  logic        q_busy2;
  logic        regWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_writeback_buffer dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .q_reg1(q_reg1), .q_reg2(q_reg2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .regWrite(regWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .count(count)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  br;
    logic [31:0] bd;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [2:0]  cnt;
    logic        brdy;
    logic        busy1;
    logic        busy2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic bv, input logic [4:0] br, input logic [31:0] bd,
                     input logic [4:0] q1, input logic [4:0] q2,
                     input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                     input logic [2:0] cnt, input logic brdy, input logic busy1, input logic busy2);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.bv = bv; v.br = br; v.bd = bd;
    v.q1 = q1; v.q2 = q2; v.rw = rw; v.wr = wr; v.wd = wd;
    v.cnt = cnt; v.brdy = brdy; v.busy1 = busy1; v.busy2 = busy2;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    q_reg1 = 5'd0;
    q_reg2 = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    chk("rst_rw", 0, {31'd0, regWrite}, 32'd0);
    chk("rst_wr", 0, {27'd0, WriteRegister}, 32'd0);
    chk("rst_wd", 0, WriteData, 32'd0);
    chk("rst_cnt", 0, {29'd0, count}, 32'd0);
    chk("rst_brdy", 0, {31'd0, b_ready}, 32'd1);

    //   av ar     ad            bv br     bd         q1     q2     rw wr     wd            cnt   brdy busy1 busy2
    add(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,     5'd5,  5'd0,  1, 5'd5,  32'hDEADBEEF, 3'd0, 1, 1, 0);
    add(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd5,  5'd0,  0, 5'd5,  32'hDEADBEEF, 3'd0, 1, 0, 0);
    add(1, 5'd0,  32'h1234,     1, 5'd0,  32'h5678,  5'd0,  5'd0,  0, 5'd5,  32'hDEADBEEF, 3'd0, 1, 0, 0);
    add(1, 5'd10, 32'hA0,       1, 5'd1,  32'h11,    5'd1,  5'd10, 1, 5'd10, 32'hA0,       3'd1, 1, 1, 1);
    add(1, 5'd11, 32'hA1,       1, 5'd2,  32'h22,    5'd2,  5'd1,  1, 5'd11, 32'hA1,       3'd2, 1, 1, 1);
    add(1, 5'd12, 32'hA2,       1, 5'd3,  32'h33,    5'd3,  5'd0,  1, 5'd12, 32'hA2,       3'd3, 1, 1, 0);
    add(1, 5'd13, 32'hA3,       1, 5'd4,  32'h44,    5'd4,  5'd0,  1, 5'd13, 32'hA3,       3'd4, 0, 1, 0);
    add(1, 5'd14, 32'hA4,       1, 5'd5,  32'h55,    5'd5,  5'd4,  1, 5'd14, 32'hA4,       3'd4, 0, 0, 1);
    add(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd1,  5'd2,  1, 5'd1,  32'h11,       3'd3, 1, 1, 1);
    add(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd1,  5'd2,  1, 5'd2,  32'h22,       3'd2, 1, 0, 1);
    add(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd4,  5'd3,  1, 5'd3,  32'h33,       3'd1, 1, 1, 1);
    add(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd3,  5'd4,  1, 5'd4,  32'h44,       3'd0, 1, 0, 1);
    add(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd4,  5'd0,  0, 5'd4,  32'h44,       3'd0, 1, 0, 0);
    add(1, 5'd20, 32'h200,      1, 5'd6,  32'h66,    5'd6,  5'd20, 1, 5'd20, 32'h200,      3'd1, 1, 1, 1);
    add(0, 5'd0,  32'h0,        1, 5'd8,  32'h88,    5'd8,  5'd6,  1, 5'd6,  32'h66,       3'd1, 1, 1, 1);
    add(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd8,  5'd6,  1, 5'd8,  32'h88,       3'd0, 1, 1, 0);
    add(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,     5'd8,  5'd0,  0, 5'd8,  32'h88,       3'd0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
      q_reg1 = vecs[i].q1;
      q_reg2 = vecs[i].q2;
      step();
      chk("vec_rw", i, {31'd0, regWrite}, {31'd0, vecs[i].rw});
      chk("vec_wr", i, {27'd0, WriteRegister}, {27'd0, vecs[i].wr});
      chk("vec_wd", i, WriteData, vecs[i].wd);
      chk("vec_cnt", i, {29'd0, count}, {29'd0, vecs[i].cnt});
      chk("vec_brdy", i, {31'd0, b_ready}, {31'd0, vecs[i].brdy});
      chk("vec_busy1", i, {31'd0, q_busy1}, {31'd0, vecs[i].busy1});
      chk("vec_busy2", i, {31'd0, q_busy2}, {31'd0, vecs[i].busy2});
    end

    // Squash: reg 7 queued behind A traffic, then overwritten by A.
    q_reg1 = 5'd7;
    q_reg2 = 5'd0;
    drive(1'b1, 5'd15, 32'h1, 1'b1, 5'd7, 32'h70);
    step();
    chk("sq_cnt1", 0, {29'd0, count}, 32'd1);
    chk("sq_busy_q", 0, {31'd0, q_busy1}, 32'd1);
    drive(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'h0);
    step();
    chk("sq_a_wr", 0, {27'd0, WriteRegister}, 32'd7);
    chk("sq_a_wd", 0, WriteData, 32'h99);
    chk("sq_cnt2", 0, {29'd0, count}, 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("sq_pop_rw", 0, {31'd0, regWrite}, 32'd0);
    chk("sq_pop_wd", 0, WriteData, 32'h99);
    chk("sq_cnt3", 0, {29'd0, count}, 32'd0);
    chk("sq_busy_lo", 0, {31'd0, q_busy1}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sq_no70", i, {31'd0, regWrite && (WriteData == 32'h70)}, 32'd0);
    end

    // Reset mid-drain with three queued entries.
    drive(1'b1, 5'd25, 32'h250, 1'b1, 5'd21, 32'h21);
    step();
    drive(1'b1, 5'd26, 32'h260, 1'b1, 5'd22, 32'h22);
    step();
    drive(1'b1, 5'd27, 32'h270, 1'b1, 5'd23, 32'h23);
    step();
    chk("rd_cnt3", 0, {29'd0, count}, 32'd3);
    reset = 1'b1;
    drive(1'b1, 5'd5, 32'h5, 1'b1, 5'd6, 32'h6);
    step();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("rd_cnt0", 0, {29'd0, count}, 32'd0);
    chk("rd_rw", 0, {31'd0, regWrite}, 32'd0);
    chk("rd_brdy", 0, {31'd0, b_ready}, 32'd1);
    chk("rd_wr", 0, {27'd0, WriteRegister}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_noissue", i, {31'd0, regWrite}, 32'd0);
    end

    // Idle-cycle B request: bypass issues after one edge, otherwise after two.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h64);
    step();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
`ifdef WB_BYPASS_EN
    chk("bp_rw1", 0, {31'd0, regWrite}, 32'd1);
    chk("bp_wr1", 0, {27'd0, WriteRegister}, 32'd9);
    chk("bp_wd1", 0, WriteData, 32'h64);
    chk("bp_cnt1", 0, {29'd0, count}, 32'd0);
    step();
    chk("bp_rw2", 0, {31'd0, regWrite}, 32'd0);
`else
    chk("bp_rw1", 0, {31'd0, regWrite}, 32'd0);
    chk("bp_cnt1", 0, {29'd0, count}, 32'd1);
    step();
    chk("bp_rw2", 0, {31'd0, regWrite}, 32'd1);
    chk("bp_wr2", 0, {27'd0, WriteRegister}, 32'd9);
    chk("bp_wd2", 0, WriteData, 32'h64);
    chk("bp_cnt2", 0, {29'd0, count}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
